uart_tx_scheduler: RTL
======================

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter WORD_W, default 32, giving the word width, a multiple of 8.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port req, input, NUM_REQ bits: bit i high means requester i holds a word to send.
REQ-006 The block SHALL have port data_in, input, NUM_REQ*WORD_W bits: slice i holds requester i's word.
REQ-007 The block SHALL have port ack, output, NUM_REQ bits: a one-cycle pulse on bit i when requester i's word is fully transmitted.
REQ-008 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-009 The block SHALL have port grant_id, output, clog2(NUM_REQ) bits: index of the requester currently being served.
REQ-010 The block SHALL have port tx_start, output, 1 bit: one-cycle start pulse to uart_tx.
REQ-011 The block SHALL have port tx_byte, output, 8 bits: the byte presented to uart_tx.
REQ-012 The block SHALL have port tx_done, input, 1 bit: pulse from uart_tx at the end of the stop bit.

Function
REQ-013 The FSM SHALL have four states: IDLE, START, WAIT, ACK.
REQ-014 In IDLE with any req bit high, the block SHALL grant round-robin, searching from last_grant+1 modulo NUM_REQ.
REQ-015 On grant, the block SHALL latch the granted word into a shift register, set grant_id, clear byte_cnt, and go to START.
REQ-016 In START, the block SHALL drive tx_start=1 for exactly one cycle with tx_byte = shift[7:0], then go to WAIT.
REQ-017 Bytes SHALL be sent LSB-byte first; 0x11223344 produces the byte order 44, 33, 22, 11.
REQ-018 tx_byte SHALL stay stable from START until the next START or until IDLE is re-entered.
REQ-019 In WAIT on tx_done: if byte_cnt = WORD_W/8-1, the block SHALL go to ACK; otherwise it SHALL shift right by 8, increment byte_cnt, and go to START.
REQ-020 In ACK, the block SHALL pulse ack[grant_id] for one cycle, set last_grant = grant_id, and go to IDLE.
REQ-021 Latency from req high in IDLE to tx_start high SHALL be 2 clock edges: grant, then START.
REQ-022 Changes on req or data_in after the grant SHALL be ignored until ACK.
REQ-023 tx_done asserted outside WAIT SHALL be ignored.
REQ-024 If a requester keeps req high after its ack, other pending requesters SHALL be served first; no requester SHALL be starved.
REQ-025 With a single requester pending continuously, that requester SHALL be re-granted in the cycle after ACK returns the FSM to IDLE.
REQ-026 When req is all zero in IDLE, all outputs SHALL hold their reset values except grant_id and tx_byte, which hold their last values.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL enter IDLE, abort any transfer in progress, and clear tx_start, ack, busy, grant_id, tx_byte, byte_cnt, and the shift register.
REQ-028 On reset, last_grant SHALL be set to NUM_REQ-1 so that requester 0 has first priority.
REQ-029 Reset SHALL take priority over every other event in the same cycle, including tx_done.

Structure
REQ-030 The state enum and the constants BYTE_W=8, WORD_W, and NUM_REQ SHALL live in the shared package uart_sched_pkg.
REQ-031 Round-robin selection SHALL be a sub-module rr_arbiter with inputs req and last_grant and outputs valid and idx; it SHALL be purely combinational.
REQ-032 The serializer and FSM SHALL remain in uart_tx_scheduler, which drives the existing uart_tx directly.

Verification
REQ-033 Reset, then req=0001 with data0=0x00000001: tx bytes 01,00,00,00; ack[0] pulses once; busy falls the cycle after ack.
REQ-034 req=1111 held with distinct words: service order 0,1,2,3,0,... and each ack matches the served grant_id.
REQ-035 Grant on requester 2, then data2 changed mid-transfer: the latched word is sent unchanged.
REQ-036 Reset asserted during WAIT of byte 2: no ack; outputs return to reset values next cycle; the next grant goes to requester 0.
REQ-037 tx_done pulsed in IDLE and in START: no state change and no byte skipped.
REQ-038 data=0x11223344 looped through the uart_tx/uart_rx pair: received bytes 44,33,22,11.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// The scheduler multiplexes several word-sized requesters onto a single
// byte-wide uart_tx, sending each word least-significant byte first.
package uart_sched_pkg;

    // Width of one UART character.
    localparam int BYTE_W  = 8;
    // Default word width; must be a multiple of BYTE_W.
    localparam int WORD_W  = 32;
    // Default number of requesters sharing the transmitter.
    localparam int NUM_REQ = 4;

    // Scheduler states.
    //   S_IDLE  : waiting for any requester, arbitration happens here
    //   S_START : present the current byte and fire the uart_tx start pulse
    //   S_WAIT  : wait for uart_tx to finish the stop bit
    //   S_ACK   : acknowledge the requester whose word has gone out
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } sched_state_e;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker. The search starts at the requester
// just after last_grant and wraps around, so the most recently served
// requester has the lowest priority and nobody can be starved.
module rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ = uart_sched_pkg::NUM_REQ,
    localparam int ID_W    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic               valid,
    output logic [ID_W-1:0]    idx
);

    // Walk the requesters in rotated order and keep the first one asking.
    always_comb begin : p_pick
        logic [ID_W-1:0] cand;
        logic            hit;
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        hit   = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand  = ID_W'((int'(last_grant) + k) % NUM_REQ);
            hit   = !valid && req[cand];
            idx   = hit ? cand : idx;
            valid = valid | hit;
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// UART transmit scheduler: grants one requester at a time (round-robin),
// latches its word, and feeds it byte by byte (LSB byte first) to an
// external uart_tx through a start/done handshake. A one-cycle ack pulse
// tells the requester when its whole word has been transmitted.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter  int NUM_REQ = uart_sched_pkg::NUM_REQ,
    parameter  int WORD_W  = uart_sched_pkg::WORD_W,
    localparam int ID_W    = idx_width(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*WORD_W-1:0] data_in,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      tx_start,
    output logic [BYTE_W-1:0]         tx_byte,
    input  logic                      tx_done
);

    localparam int                NUM_BYTES = WORD_W / BYTE_W;
    localparam int                CNT_W     = idx_width(NUM_BYTES);
    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(NUM_BYTES - 1);
    localparam logic [ID_W-1:0]   LAST_REQ  = ID_W'(NUM_REQ - 1);

    sched_state_e         state_q;
    logic [WORD_W-1:0]    shift_q;
    logic [CNT_W-1:0]     byte_cnt_q;
    logic [ID_W-1:0]      last_grant_q;
    logic [ID_W-1:0]      grant_id_q;
    logic                 tx_start_q;
    logic [BYTE_W-1:0]    tx_byte_q;
    logic [NUM_REQ-1:0]   ack_q;
    logic                 busy_q;

    logic                 arb_valid;
    logic [ID_W-1:0]      arb_idx;
    logic [WORD_W-1:0]    sel_word;

    rr_arbiter #(
        .NUM_REQ    (NUM_REQ)
    ) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .valid      (arb_valid),
        .idx        (arb_idx)
    );

    // Word of the requester the arbiter is currently pointing at.
    always_comb begin
        sel_word = data_in[arb_idx*WORD_W +: WORD_W];
    end

    // Scheduler FSM with serializer; every output is a register.
    // tx_start and ack default low so they can only ever be single-cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= '0;
            last_grant_q <= LAST_REQ;
            grant_id_q   <= '0;
            tx_start_q   <= 1'b0;
            tx_byte_q    <= '0;
            ack_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            tx_start_q <= 1'b0;
            ack_q      <= '0;
            case (state_q)
                S_IDLE: begin
                    if (arb_valid) begin
                        // Latch the word now: later req/data changes are ignored.
                        shift_q    <= sel_word;
                        grant_id_q <= arb_idx;
                        byte_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_START;
                    end else begin
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end
                S_START: begin
                    tx_start_q <= 1'b1;
                    tx_byte_q  <= shift_q[BYTE_W-1:0];
                    state_q    <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            // ack is visible for the whole ACK state.
                            ack_q   <= NUM_REQ'(1'b1) << grant_id_q;
                            state_q <= S_ACK;
                        end else begin
                            shift_q    <= shift_q >> BYTE_W;
                            byte_cnt_q <= byte_cnt_q + 1'b1;
                            state_q    <= S_START;
                        end
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_ACK: begin
                    // Served requester drops to lowest priority next round.
                    last_grant_q <= grant_id_q;
                    busy_q       <= 1'b0;
                    state_q      <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign grant_id = grant_id_q;
    assign tx_start = tx_start_q;
    assign tx_byte  = tx_byte_q;

endmodule
